// File: rtl/gravsim_pkg.sv
// Shared types and constants for the GravSim multi-body pixel engine.
package gravsim_pkg;

  localparam int COORD_W  = 10;
  localparam int RADIUS_W = 6;
  localparam int PIPE_LAT = 3;

  // One body as software sees it, sized for the default configuration.
  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [RADIUS_W-1:0] r;
  } body_t;

endpackage

// File: rtl/body_hit_test.sv
// Per-body distance test: S1 offset, S2 squared distance/radius, S3 compare.
// The compare result is combinational from the S2 registers; the top registers it.
module body_hit_test
  import gravsim_pkg::*;
#(
  parameter int COORD_W  = 10,
  parameter int RADIUS_W = 6
) (
  input  logic                Clk,
  input  logic [COORD_W-1:0]  body_x,
  input  logic [COORD_W-1:0]  body_y,
  input  logic [RADIUS_W-1:0] body_r,
  input  logic [COORD_W-1:0]  DrawX,
  input  logic [COORD_W-1:0]  DrawY,
  output logic                hit
);

  localparam int SQ_W = 2 * COORD_W + 2;
  localparam int D2_W = 2 * COORD_W + 3;
  localparam int R2_W = 2 * RADIUS_W;

  logic signed [COORD_W:0] s1_dx;
  logic signed [COORD_W:0] s1_dy;
  logic [RADIUS_W-1:0]     s1_r;

  logic signed [SQ_W-1:0]  dx_ext;
  logic signed [SQ_W-1:0]  dy_ext;
  logic signed [SQ_W-1:0]  sq_x;
  logic signed [SQ_W-1:0]  sq_y;
  logic [R2_W-1:0]         r_ext;

  logic [D2_W-1:0]         s2_d2;
  logic [R2_W-1:0]         s2_r2;
  logic                    s2_en;

  // S1: signed offsets with an extra sign bit so dx/dy can never wrap.
  always_ff @(posedge Clk) begin
    s1_dx <= $signed({1'b0, DrawX}) - $signed({1'b0, body_x});
    s1_dy <= $signed({1'b0, DrawY}) - $signed({1'b0, body_y});
    s1_r  <= body_r;
  end

  assign dx_ext = {{(COORD_W+1){s1_dx[COORD_W]}}, s1_dx};
  assign dy_ext = {{(COORD_W+1){s1_dy[COORD_W]}}, s1_dy};
  assign sq_x   = dx_ext * dx_ext;
  assign sq_y   = dy_ext * dy_ext;
  assign r_ext  = {{RADIUS_W{1'b0}}, s1_r};

  // S2: squared distance wide enough that the sum cannot overflow.
  always_ff @(posedge Clk) begin
    s2_d2 <= {1'b0, sq_x} + {1'b0, sq_y};
    s2_r2 <= r_ext * r_ext;
    s2_en <= (s1_r != '0);
  end

  assign hit = s2_en && (s2_d2 <= {{(D2_W-R2_W){1'b0}}, s2_r2});

endmodule

// File: rtl/body_pixel_engine.sv
// Multi-body pixel engine: shadow/active body sets, vsync commit, 3-stage hit pipeline.
// Optional macro BODY_COLLIDE_EN adds a sticky multi-body collision flag.
module body_pixel_engine
  import gravsim_pkg::*;
#(
  parameter int N_BODIES = 4,
  parameter int COORD_W  = 10,
  parameter int RADIUS_W = 6,
  parameter int ID_W     = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                wr_en,
  input  logic [ID_W-1:0]     wr_idx,
  input  logic [COORD_W-1:0]  wr_x,
  input  logic [COORD_W-1:0]  wr_y,
  input  logic [RADIUS_W-1:0] wr_r,
  output logic                wr_err,
  input  logic                VGA_VS,
  output logic                commit_done,
  input  logic                pix_valid,
  input  logic [COORD_W-1:0]  DrawX,
  input  logic [COORD_W-1:0]  DrawY,
  output logic                hit_valid,
  output logic                is_ball,
  output logic [ID_W-1:0]     body_id,
  output logic                collide
);

  localparam logic [ID_W:0] N_LIMIT = (ID_W+1)'(N_BODIES);

  logic [COORD_W-1:0]  shadow_x [N_BODIES];
  logic [COORD_W-1:0]  shadow_y [N_BODIES];
  logic [RADIUS_W-1:0] shadow_r [N_BODIES];
  logic [COORD_W-1:0]  active_x [N_BODIES];
  logic [COORD_W-1:0]  active_y [N_BODIES];
  logic [RADIUS_W-1:0] active_r [N_BODIES];

  logic                vs_prev;
  logic                commit;
  logic                idx_ok;
  logic [PIPE_LAT-1:0] vld;
  logic [N_BODIES-1:0] hit;
  logic                any_hit;
  logic [ID_W-1:0]     first_id;

  assign commit    = vs_prev && !VGA_VS;
  assign idx_ok    = ({1'b0, wr_idx} < N_LIMIT);
  assign hit_valid = vld[PIPE_LAT-1];

  // Shadow writes land at the edge; the commit copies the pre-write shadow.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_BODIES; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
        shadow_r[i] <= '0;
        active_x[i] <= '0;
        active_y[i] <= '0;
        active_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BODIES; i++) begin
        if (wr_en && (wr_idx == ID_W'(i))) begin
          shadow_x[i] <= wr_x;
          shadow_y[i] <= wr_y;
          shadow_r[i] <= wr_r;
        end
        if (commit) begin
          active_x[i] <= shadow_x[i];
          active_y[i] <= shadow_y[i];
          active_r[i] <= shadow_r[i];
        end
      end
    end
  end

  // Control pulses, vsync history and the valid pipeline.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vs_prev     <= 1'b1;
      wr_err      <= 1'b0;
      commit_done <= 1'b0;
      vld         <= '0;
    end else begin
      vs_prev     <= VGA_VS;
      wr_err      <= wr_en && !idx_ok;
      commit_done <= commit;
      vld         <= {vld[PIPE_LAT-2:0], pix_valid};
    end
  end

  for (genvar g = 0; g < N_BODIES; g++) begin : g_body
    body_hit_test #(
      .COORD_W (COORD_W),
      .RADIUS_W(RADIUS_W)
    ) u_hit (
      .Clk   (Clk),
      .body_x(active_x[g]),
      .body_y(active_y[g]),
      .body_r(active_r[g]),
      .DrawX (DrawX),
      .DrawY (DrawY),
      .hit   (hit[g])
    );
  end

  // Priority encode: scanning downward leaves the lowest hit index.
  always_comb begin
    any_hit  = 1'b0;
    first_id = '0;
    for (int i = N_BODIES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit  = 1'b1;
        first_id = ID_W'(i);
      end
    end
  end

  // S3 output register, held when no valid pixel reaches this stage.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      is_ball <= 1'b0;
      body_id <= '0;
    end else if (vld[PIPE_LAT-2]) begin
      is_ball <= any_hit;
      body_id <= first_id;
    end
  end

`ifdef BODY_COLLIDE_EN
  logic [ID_W:0] hit_count;
  logic          multi_hit;

  // Count simultaneous hits for the collision flag.
  always_comb begin
    hit_count = '0;
    for (int i = 0; i < N_BODIES; i++) begin
      hit_count = hit_count + {{ID_W{1'b0}}, hit[i]};
    end
    multi_hit = vld[PIPE_LAT-2] && (hit_count >= (ID_W+1)'(2));
  end

  // Sticky until commit; a collision in the commit cycle keeps it set.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      collide <= 1'b0;
    end else if (multi_hit) begin
      collide <= 1'b1;
    end else if (commit) begin
      collide <= 1'b0;
    end
  end
`else
  assign collide = 1'b0;
`endif

endmodule

// File: doc/body_pixel_engine.md
Name: body_pixel_engine

Overview:
- Parametrised multi-body successor to the single-ball pixel test in the GravSim VGA path.
- Software loads per-body position and radius into shadow registers.
- Shadow set is committed atomically at frame boundary (vsync); each incoming (DrawX, DrawY) is tested against all bodies through a 3-stage pipeline.
- Outputs is_ball plus the winning body index for the color mapper.

Parameters:
- N_BODIES, 4, number of bodies tested per pixel (1..16)
- COORD_W, 10, width of DrawX/DrawY and body coordinates (unsigned)
- RADIUS_W, 6, width of body radius (unsigned)
- ID_W, 4, width of body index outputs; must satisfy 2**ID_W >= N_BODIES

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  synchronous active-low reset
- wr_en  in  1  write strobe for one shadow body entry
- wr_idx  in  ID_W  body index to write
- wr_x  in  COORD_W  body centre X
- wr_y  in  COORD_W  body centre Y
- wr_r  in  RADIUS_W  body radius; 0 = body disabled
- wr_err  out  1  one-cycle pulse: wr_idx >= N_BODIES, write dropped
- VGA_VS  in  1  vertical sync, active low
- commit_done  out  1  one-cycle pulse when shadow copied to active set
- pix_valid  in  1  DrawX/DrawY valid this cycle (pixel-clock enable)
- DrawX  in  COORD_W  current pixel X
- DrawY  in  COORD_W  current pixel Y
- hit_valid  out  1  pix_valid delayed 3 cycles
- is_ball  out  1  pixel lies inside at least one enabled body
- body_id  out  ID_W  lowest index among hit bodies; 0 when no hit
- collide  out  1  sticky multi-body flag (see Optional Feature)

Behaviour:
- Reset (Reset_n low at posedge Clk):
  - all shadow and active entries cleared (x = y = r = 0)
  - pipeline valids cleared; VGA_VS history register set to 1
  - all outputs 0
- Reset asserted mid-frame discards in-flight pixels; no hit_valid for the following 3 cycles.
- Shadow write: wr_en with wr_idx < N_BODIES updates shadow[wr_idx] at the next edge. Otherwise nothing is written and wr_err pulses on the next cycle.
- Commit:
  - Triggered on the cycle VGA_VS is sampled 0 while its previous sample was 1 (falling edge).
  - Entire shadow array copied to active array in that cycle; commit_done pulses the next cycle.
  - Same-cycle wr_en and commit: active receives the pre-write shadow value; the new write stays in shadow for the next frame.
- Pixel pipeline (fixed latency 3, fully pipelined, one pixel/cycle; stages advance every cycle and carry valid):
  - S1: dx = DrawX - x_i, dy = DrawY - y_i, signed COORD_W+1 bits, for each body i.
  - S2: d2 = dx*dx + dy*dy, unsigned 2*COORD_W+3 bits (no overflow); r2 = r_i*r_i, 2*RADIUS_W bits zero-extended.
  - S3: hit_i = (r_i != 0) && (d2 <= r2). is_ball = OR of hit_i; body_id = priority encode, lowest i wins. Outputs registered.
- Active array changes only at commit, so a pixel already in the pipeline uses the set it sampled in S1.
- Outputs is_ball/body_id update only when the S3 valid is set; otherwise they hold their previous values.
- Coordinates are unsigned: negative offscreen centres are not representable, while wrap-around of dx is impossible due to the sign bit.

Optional Feature:
- Macro: BODY_COLLIDE_EN.
- Defined:
  - Any S3 pixel with two or more hit_i sets collide.
  - collide stays set until the next commit, which clears it in the commit cycle; a collision in the same cycle as a commit wins, so collide remains 1.
  - Popcount logic is compiled in.
- Undefined: collide tied to 0 and no popcount logic is synthesised.

Decomposition:
- Package gravsim_pkg:
  - body_t struct {x, y, r}, parameterised via localparams COORD_W/RADIUS_W defaults
  - constant PIPE_LAT = 3
- Sub-module body_hit_test:
  - one per body via generate
  - performs S1–S2 arithmetic and the S3 compare, emitting hit_i
- The top handles shadow/active registers, commit detection, priority encode and collide.

Test Plan:
- Reset: hold Reset_n=0 for 2 cycles with pix_valid=1 -> all outputs 0, no hit_valid for 3 cycles after release.
- Single body: write idx0 (x=320, y=240, r=10), VGA_VS 1->0, pixel (330,240) -> after commit_done, 3 cycles later is_ball=1, body_id=0; pixel (331,240) -> is_ball=0.
- Priority: idx1 (100,100,r=20), idx2 (105,100,r=20), pixel (104,100) -> is_ball=1, body_id=1; with BODY_COLLIDE_EN, collide=1 until the next commit.
- Atomic commit: write idx0 r=5 in the same cycle as the VGA_VS falling edge -> active r keeps the old value 10 this frame; next commit applies r=5.
- Bad index: wr_en with wr_idx=7, N_BODIES=4 -> wr_err pulse, shadow unchanged.
- Disabled body: idx3 (0,0,r=0), pixel (0,0) -> is_ball=0.
